// File: rtl/mat_op_sequencer_pkg.sv
// Shared constants for the matrix-operation sequencer:
// opcodes, default dimension exponent and FSM state encoding.
package mat_op_sequencer_pkg;

  localparam int WIDTH_BIT = 2;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_MUL    = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd3;
  localparam logic [2:0] OP_MOD    = 3'd4;
  localparam logic [2:0] OP_MATMUL = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_EXEC,
    ST_DRAIN
  } state_t;

  function automatic logic op_bad(input logic [2:0] op);
    return op > OP_MATMUL;
  endfunction

endpackage

// File: rtl/mat_serdes.sv
// Element indexing and serial/parallel conversion: streams
// operands into A/B, captures the result and serialises it.
module mat_serdes #(
  parameter int WIDTH = 4,
  parameter int IW    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [IW-1:0]                        idx,
  input  logic                                 wr_a,
  input  logic                                 wr_b,
  input  logic                                 cap,
  input  logic                                 zero,
  input  logic signed [31:0]                   in_data,
  input  logic signed [0:WIDTH-1][0:WIDTH-1][31:0] op_result,
  output logic signed [0:WIDTH-1][0:WIDTH-1][31:0] op_a,
  output logic signed [0:WIDTH-1][0:WIDTH-1][31:0] op_b,
  output logic signed [31:0]                   out_data
);

  localparam int RW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic signed [0:WIDTH-1][0:WIDTH-1][31:0] res;
  logic [RW-1:0] row;
  logic [RW-1:0] col;

  assign row = RW'(idx / IW'(WIDTH));
  assign col = RW'(idx % IW'(WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
      res  <= '0;
    end else begin
      if (wr_a) op_a[row][col] <= in_data;
      if (wr_b) op_b[row][col] <= in_data;
      // unsupported opcodes drain zeros rather than whatever the unit drives
      if (cap)  res <= zero ? '0 : op_result;
    end
  end

  assign out_data = $signed(res[row][col]);

endmodule

// File: rtl/mat_op_sequencer.sv
// Command/operand sequencer around an external matrix
// arithmetic unit: load A, load B, one-cycle exec, drain R.
module mat_op_sequencer
  import mat_op_sequencer_pkg::*;
#(
  parameter int WIDTH = 2 ** WIDTH_BIT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmd_valid,
  input  logic [2:0]                           cmd_op,
  output logic                                 cmd_ready,
  input  logic                                 in_valid,
  input  logic signed [31:0]                   in_data,
  output logic                                 in_ready,
  output logic signed [0:WIDTH-1][0:WIDTH-1][31:0] op_a,
  output logic signed [0:WIDTH-1][0:WIDTH-1][31:0] op_b,
  output logic [2:0]                           op_sel,
  input  logic signed [0:WIDTH-1][0:WIDTH-1][31:0] op_result,
  output logic                                 out_valid,
  output logic signed [31:0]                   out_data,
  output logic                                 out_last,
  input  logic                                 out_ready,
  output logic                                 err
);

  localparam int N  = WIDTH * WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic          wr_a;
  logic          wr_b;
  logic          cap;
  logic          at_last;

  assign wr_a    = (state == ST_LOAD_A) && in_valid && in_ready;
  assign wr_b    = (state == ST_LOAD_B) && in_valid && in_ready;
  assign cap     = (state == ST_EXEC);
  assign at_last = (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      op_sel    <= OP_ADD;
      cmd_ready <= 1'b1;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_sel    <= cmd_op;
            idx       <= '0;
            state     <= ST_LOAD_A;
            cmd_ready <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        ST_LOAD_A: begin
          if (in_valid) begin
            if (at_last) begin
              idx   <= '0;
              state <= ST_LOAD_B;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_LOAD_B: begin
          if (in_valid) begin
            if (at_last) begin
              idx      <= '0;
              state    <= ST_EXEC;
              in_ready <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_EXEC: begin
          state     <= ST_DRAIN;
          out_valid <= 1'b1;
          out_last  <= (N == 1);
          err       <= op_bad(op_sel);
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (at_last) begin
              idx       <= '0;
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              err       <= 1'b0;
              cmd_ready <= 1'b1;
            end else begin
              idx      <= idx + 1'b1;
              out_last <= ((idx + 1'b1) == LAST);
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          idx       <= '0;
          cmd_ready <= 1'b1;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          err       <= 1'b0;
        end
      endcase
    end
  end

  mat_serdes #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_serdes (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .wr_a      (wr_a),
    .wr_b      (wr_b),
    .cap       (cap),
    .zero      (op_bad(op_sel)),
    .in_data   (in_data),
    .op_result (op_result),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_mat_op_sequencer.sv
// Bench for mat_op_sequencer: behavioural arithmetic unit plus
// a flat-array reference model, per-scenario tasks.
module tb_mat_op_sequencer;
  import mat_op_sequencer_pkg::*;

  localparam int W = 4;
  localparam int N = W * W;
  typedef int vec_t[N];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic cmd_ready;
  logic in_valid = 1'b0;
  logic signed [31:0] in_data = '0;
  logic in_ready;
  logic signed [0:W-1][0:W-1][31:0] op_a, op_b, op_result;
  logic [2:0] op_sel;
  logic out_valid;
  logic signed [31:0] out_data;
  logic out_last;
  logic out_ready = 1'b0;
  logic err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  mat_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .op_result(op_result),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural arithmetic unit driven by the DUT's registered operands
  always_comb begin
    int x, y, acc;
    x = 0; y = 0; acc = 0;
    op_result = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        x = $signed(op_a[i][j]);
        y = $signed(op_b[i][j]);
        acc = 0;
        case (op_sel)
          OP_ADD: acc = x + y;
          OP_SUB: acc = x - y;
          OP_MUL: acc = x * y;
          OP_DIV: acc = (y != 0) ? x / y : 0;
          OP_MOD: acc = (y != 0) ? x % y : 0;
          OP_MATMUL:
            for (int k = 0; k < W; k++)
              acc += $signed(op_a[i][k]) * $signed(op_b[k][j]);
          default: acc = 0;
        endcase
        op_result[i][j] = acc;
      end
    end
  end

  function automatic vec_t ref_model(input int op, input vec_t a, input vec_t b);
    vec_t r;
    for (int e = 0; e < N; e++) begin
      int s;
      s = 0;
      case (3'(op))
        OP_ADD: s = a[e] + b[e];
        OP_SUB: s = a[e] - b[e];
        OP_MUL: s = a[e] * b[e];
        OP_DIV: s = (b[e] != 0) ? a[e] / b[e] : 0;
        OP_MOD: s = (b[e] != 0) ? a[e] % b[e] : 0;
        OP_MATMUL:
          for (int k = 0; k < W; k++)
            s += a[(e / W) * W + k] * b[k * W + (e % W)];
        default: s = 0;
      endcase
      r[e] = s;
    end
    return r;
  endfunction

  function automatic int rnd_val();
    return int'($urandom_range(0, 2000)) - 1000;
  endfunction

  task automatic send_cmd(input int op, output int neg_cyc);
    int t;
    t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL cmd_timeout got cmd_ready=%b want 1", cmd_ready);
    end
    neg_cyc = cyc;
    cmd_valid = 1'b1;
    cmd_op = 3'(op);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic stream(input vec_t a, input vec_t b, input int nb, input bit gaps);
    int t;
    for (int e = 0; e < N + nb; e++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      t = 0;
      while (!in_ready && t < 50) begin
        in_valid = 1'b0;
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        total++; bad++;
        $display("FAIL in_ready_timeout elem=%0d got 0 want 1", e);
        break;
      end
      in_valid = 1'b1;
      in_data = (e < N) ? a[e] : b[e - N];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int mode, output vec_t d, output int cnt,
                         output int last_bad, output int err_cnt, output int hold_bad,
                         output int first_cyc, output int last_cyc);
    int t;
    bit done, stalled;
    logic signed [31:0] pd;
    logic pl;
    t = 0; done = 0; stalled = 0; pd = '0; pl = 1'b0;
    cnt = 0; last_bad = 0; err_cnt = 0; hold_bad = 0;
    first_cyc = -1; last_cyc = -1;
    for (int e = 0; e < N; e++) d[e] = 0;
    while (!done && t < 400) begin
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (stalled && (out_data !== pd || out_last !== pl)) hold_bad++;
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = !out_ready;
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (out_ready) begin
          if (cnt < N) d[cnt] = out_data;
          if (out_last !== (cnt == N - 1)) last_bad++;
          if (err) err_cnt++;
          cnt++;
          if (out_last) begin
            done = 1;
            last_cyc = cyc;
          end
        end
        stalled = !out_ready;
        pd = out_data;
        pl = out_last;
      end
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout got %0d elems want %0d", cnt, N);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || err !== 1'b0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_outs got v=%b ir=%b e=%b l=%b want 0000", out_valid, in_ready, err, out_last);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
    end
    total++;
    if (op_sel !== 3'd0 || op_a !== '0 || op_b !== '0) begin
      bad++;
      $display("FAIL reset_regs got op_sel=%0d a_or_b_nonzero=%b want 0", op_sel, (op_a !== '0) || (op_b !== '0));
    end
  endtask

  task automatic test_add();
    vec_t a, b, d, ex;
    int nc, cnt, lb, ec, hb, fc, lc;
    for (int e = 0; e < N; e++) begin
      a[e] = e;
      b[e] = 100;
      ex[e] = 100 + e;
    end
    send_cmd(0, nc);
    stream(a, b, N, 0);
    collect(0, d, cnt, lb, ec, hb, fc, lc);
    for (int e = 0; e < N; e++) begin
      total++;
      if (d[e] !== ex[e]) begin
        bad++;
        $display("FAIL add_data[%0d] got %0d want %0d", e, d[e], ex[e]);
      end
    end
    total++;
    if (cnt !== N || lb !== 0) begin
      bad++;
      $display("FAIL add_last got cnt=%0d last_bad=%0d want cnt=%0d last_bad=0", cnt, lb, N);
    end
    total++;
    if (fc - nc !== 2 * N + 2) begin
      bad++;
      $display("FAIL add_latency got %0d want %0d", fc - nc, 2 * N + 2);
    end
    total++;
    if (ec !== 0) begin
      bad++;
      $display("FAIL add_err got %0d want 0", ec);
    end
  endtask

  task automatic test_matmul_stall();
    vec_t a, b, d;
    int nc, cnt, lb, ec, hb, fc, lc;
    for (int e = 0; e < N; e++) begin
      a[e] = (e / W == e % W) ? 1 : 0;
      b[e] = e;
    end
    send_cmd(5, nc);
    stream(a, b, N, 1);
    collect(1, d, cnt, lb, ec, hb, fc, lc);
    for (int e = 0; e < N; e++) begin
      total++;
      if (d[e] !== e) begin
        bad++;
        $display("FAIL matmul_data[%0d] got %0d want %0d", e, d[e], e);
      end
    end
    total++;
    if (hb !== 0 || cnt !== N || lb !== 0) begin
      bad++;
      $display("FAIL matmul_stall got hold_bad=%0d cnt=%0d last_bad=%0d want 0 %0d 0", hb, cnt, lb, N);
    end
  endtask

  task automatic test_bad_op();
    vec_t a, b, d;
    int nc, cnt, lb, ec, hb, fc, lc;
    for (int e = 0; e < N; e++) begin
      a[e] = rnd_val();
      b[e] = rnd_val();
    end
    send_cmd(7, nc);
    stream(a, b, N, 0);
    collect(2, d, cnt, lb, ec, hb, fc, lc);
    for (int e = 0; e < N; e++) begin
      total++;
      if (d[e] !== 0) begin
        bad++;
        $display("FAIL badop_data[%0d] got %0d want 0", e, d[e]);
      end
    end
    total++;
    if (ec !== N || cnt !== N) begin
      bad++;
      $display("FAIL badop_err got err=%0d cnt=%0d want %0d %0d", ec, cnt, N, N);
    end
    total++;
    if (cmd_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL badop_idle got cr=%b v=%b e=%b want 1 0 0", cmd_ready, out_valid, err);
    end
  endtask

  task automatic test_reset_mid();
    vec_t a, b, d, ex;
    int nc, cnt, lb, ec, hb, fc, lc, spur;
    for (int e = 0; e < N; e++) begin
      a[e] = rnd_val();
      b[e] = rnd_val();
    end
    send_cmd(1, nc);
    stream(a, b, 9, 0);
    #2 rst = 1'b1;
    #2;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async got v=%b ir=%b want 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || out_valid !== 1'b0 || op_a !== '0 || op_b !== '0) begin
      bad++;
      $display("FAIL midrst_state got cr=%b v=%b want 1 0 with zero operands", cmd_ready, out_valid);
    end
    spur = 0;
    repeat (6) begin
      if (out_valid) spur++;
      @(negedge clk);
    end
    total++;
    if (spur !== 0) begin
      bad++;
      $display("FAIL midrst_spurious got %0d want 0", spur);
    end
    for (int e = 0; e < N; e++) begin
      a[e] = rnd_val();
      b[e] = rnd_val();
    end
    ex = ref_model(1, a, b);
    send_cmd(1, nc);
    stream(a, b, N, 1);
    collect(0, d, cnt, lb, ec, hb, fc, lc);
    for (int e = 0; e < N; e++) begin
      total++;
      if (d[e] !== ex[e]) begin
        bad++;
        $display("FAIL sub_data[%0d] got %0d want %0d", e, d[e], ex[e]);
      end
    end
  endtask

  task automatic test_ignore();
    vec_t a, b, d, ex;
    int nc, cnt, lb, ec, hb, fc, lc, spur;
    for (int e = 0; e < N; e++) begin
      a[e] = rnd_val();
      b[e] = rnd_val();
    end
    ex = ref_model(0, a, b);
    send_cmd(0, nc);
    cmd_valid = 1'b1;
    cmd_op = 3'd5;
    stream(a, b, N, 0);
    cmd_valid = 1'b0;
    in_valid = 1'b1;
    in_data = 32'sd12345;
    collect(2, d, cnt, lb, ec, hb, fc, lc);
    spur = 0;
    out_ready = 1'b1;
    repeat (4) begin
      if (out_valid) spur++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    for (int e = 0; e < N; e++) begin
      total++;
      if (d[e] !== ex[e]) begin
        bad++;
        $display("FAIL ignore_data[%0d] got %0d want %0d", e, d[e], ex[e]);
      end
    end
    total++;
    if (cnt + spur !== N || op_sel !== 3'd0) begin
      bad++;
      $display("FAIL ignore_count got %0d op_sel=%0d want %0d op_sel=0", cnt + spur, op_sel, N);
    end
  endtask

  task automatic test_back_to_back();
    vec_t a, b, d, ex;
    int nc, cnt, lb, ec, hb, fc, lc;
    int ops[2];
    ops[0] = 2;
    ops[1] = 4;
    for (int r = 0; r < 2; r++) begin
      for (int e = 0; e < N; e++) begin
        a[e] = rnd_val();
        b[e] = rnd_val();
        if (b[e] == 0) b[e] = 7;
      end
      ex = ref_model(ops[r], a, b);
      send_cmd(ops[r], nc);
      if (r == 1) begin
        total++;
        if (nc !== lc + 1) begin
          bad++;
          $display("FAIL b2b_accept got offset=%0d want 1", nc - lc);
        end
      end
      stream(a, b, N, 0);
      collect(0, d, cnt, lb, ec, hb, fc, lc);
      for (int e = 0; e < N; e++) begin
        total++;
        if (d[e] !== ex[e]) begin
          bad++;
          $display("FAIL b2b%0d_data[%0d] got %0d want %0d", r, e, d[e], ex[e]);
        end
      end
    end
  endtask

  task automatic test_random();
    vec_t a, b, d, ex;
    int nc, cnt, lb, ec, hb, fc, lc, op;
    for (int r = 0; r < 6; r++) begin
      op = int'($urandom_range(0, 7));
      for (int e = 0; e < N; e++) begin
        a[e] = rnd_val();
        b[e] = rnd_val();
        if (b[e] == 0) b[e] = 3;
      end
      ex = ref_model(op, a, b);
      send_cmd(op, nc);
      stream(a, b, N, 1);
      collect(2, d, cnt, lb, ec, hb, fc, lc);
      for (int e = 0; e < N; e++) begin
        total++;
        if (d[e] !== ex[e]) begin
          bad++;
          $display("FAIL rand%0d_op%0d[%0d] got %0d want %0d", r, op, e, d[e], ex[e]);
        end
      end
      total++;
      if (hb !== 0 || lb !== 0 || ec !== ((op > 5) ? N : 0)) begin
        bad++;
        $display("FAIL rand%0d_flags got hold=%0d last=%0d err=%0d want 0 0 %0d", r, hb, lb, ec, (op > 5) ? N : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_matmul_stall();
    test_bad_op();
    test_reset_mid();
    test_ignore();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
